// File: rtl/ristretto_if_id_queue_pkg.sv
// ristretto_if_id_queue_pkg
//   Shared definitions for the IF/ID decoupling queue.
//   - NOP_INSTR      : word shown to decode while the queue is empty (addi x0,x0,0)
//   - if_id_entry_t  : {instr, pc, tag} triple at the core's default widths
//   - SQUASH_CNT_W   : width of the saturating squashed-entry counter
//   - squash_sat_add : saturating add used by the squash counter
package ristretto_if_id_queue_pkg;

    localparam int IF_ID_DATA_W = 32;
    localparam int IF_ID_ADDR_W = 32;

    localparam logic [IF_ID_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int SQUASH_CNT_W = 8;
    localparam logic [31:0] SQUASH_CNT_MAX = (32'd1 << SQUASH_CNT_W) - 32'd1;

    typedef struct packed {
        logic [IF_ID_DATA_W-1:0] instr;
        logic [IF_ID_ADDR_W-1:0] pc;
        logic                    tag;
    } if_id_entry_t;

    // Adds inc to cnt and clamps at the counter's all-ones value.
    function automatic logic [SQUASH_CNT_W-1:0] squash_sat_add(
        input logic [SQUASH_CNT_W-1:0] cnt,
        input logic [31:0]             inc
    );
        logic [31:0] sum;
        sum = 32'(cnt) + inc;
        if (sum > SQUASH_CNT_MAX) begin
            return '1;
        end
        return sum[SQUASH_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ristretto_sync_fifo.sv
// ristretto_sync_fifo
//   Circular-buffer FIFO with a separately tracked occupancy count so that
//   full and empty are unambiguous even though the pointers wrap naturally.
//   Writes become visible at the head one cycle after the push (no bypass).
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   clr_i         : synchronous clear of pointers and count (has priority)
//   push_i/wdata_i: write an entry (caller guarantees space, or a pop this cycle)
//   pop_i         : drop the head entry (caller guarantees non-empty)
//   rdata_o       : head entry (undefined content while empty)
//   count_o       : occupancy, full_o / empty_o : status flags
module ristretto_sync_fifo #(
    parameter int Width = 65,
    parameter int Depth = 2
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PtrW = $clog2(Depth);

    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PtrW+1)'(1);
                2'b01:   count_d = count_q - (PtrW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; validity is governed by count_q.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ristretto_if_id_queue.sv
// ristretto_if_id_queue
//   Decoupling queue between instruction fetch and decode.
//   Captures {instr, pc, tag} on id_new_instr_i, presents the oldest entry to
//   decode with a valid/stall handshake, issues credit-based fetch-enable
//   pulses and squashes everything on a control or trap hazard.
// Ports:
//   clk_i, rstn_i                 : clock, asynchronous active-low reset
//   id_run_i, id_if_busy_i        : fetch permission / fetch stage busy
//   id_new_instr_i, id_instr_i,
//   id_pc_i, id_tag_i             : instruction delivered by fetch
//   id_ctrl_hazard_flag_i,
//   id_trap_hazard_flag_i         : flush requests
//   id_stall_i                    : decode cannot take the head this cycle
//   id_fetch_en_o                 : fetch-enable pulse to the fetch stage
//   id_valid_o, id_instr_o,
//   id_pc_o, id_tag_o             : head entry (NOP / 0 / 0 while empty)
//   id_count_o                    : occupancy
//   id_overflow_o                 : sticky push-while-full error
//   id_squash_cnt_o               : saturating count of discarded entries
module ristretto_if_id_queue
    import ristretto_if_id_queue_pkg::*;
#(
    parameter int                    DataWidth = 32,
    parameter int                    AddrWidth = 32,
    parameter int                    Depth     = 2,
    parameter logic [DataWidth-1:0]  NopInstr  = DataWidth'(NOP_INSTR)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      id_run_i,
    input  logic                      id_if_busy_i,
    input  logic                      id_new_instr_i,
    input  logic [DataWidth-1:0]      id_instr_i,
    input  logic [AddrWidth-1:0]      id_pc_i,
    input  logic                      id_tag_i,
    input  logic                      id_ctrl_hazard_flag_i,
    input  logic                      id_trap_hazard_flag_i,
    input  logic                      id_stall_i,
    output logic                      id_fetch_en_o,
    output logic                      id_valid_o,
    output logic [DataWidth-1:0]      id_instr_o,
    output logic [AddrWidth-1:0]      id_pc_o,
    output logic                      id_tag_o,
    output logic [$clog2(Depth):0]    id_count_o,
    output logic                      id_overflow_o,
    output logic [SQUASH_CNT_W-1:0]   id_squash_cnt_o
);

    localparam int CntW   = $clog2(Depth) + 1;
    localparam int EntryW = DataWidth + AddrWidth + 1;

    logic              flush;
    logic              pop;
    logic              push;
    logic              credit;
    logic              fetch_en;
    logic [EntryW-1:0] head_data;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic                    outstanding_q, outstanding_d;
    logic                    overflow_q, overflow_d;
    logic [SQUASH_CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    ristretto_sync_fifo #(
        .Width (EntryW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({id_instr_i, id_pc_i, id_tag_i}),
        .rdata_o (head_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        flush = id_ctrl_hazard_flag_i | id_trap_hazard_flag_i;
        pop   = ~fifo_empty & ~id_stall_i & ~flush;
        // A pop frees the slot in the same cycle, so a full queue still accepts.
        push  = id_new_instr_i & ~flush & (~fifo_full | pop);

        // Credit depends on the pop only, never on a push arriving this cycle.
        credit = ~fifo_full | pop;
        // Gated by rstn_i so the pulse is low during reset, not only after it.
        fetch_en = rstn_i & id_run_i &
                   (flush | (~id_if_busy_i & ~outstanding_q & credit));

        // Clear first, then set: a strobe coinciding with a new request
        // leaves the flag tracking the new request.
        outstanding_d = outstanding_q;
        if (id_new_instr_i | flush) begin
            outstanding_d = 1'b0;
        end
        if (fetch_en & ~flush) begin
            outstanding_d = 1'b1;
        end

        overflow_d = overflow_q |
                     (id_new_instr_i & ~flush & fifo_full & ~pop);

        squash_cnt_d = squash_cnt_q;
        if (flush) begin
            squash_cnt_d = squash_sat_add(squash_cnt_q,
                                          32'(fifo_count) + 32'(id_new_instr_i));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outstanding_q <= 1'b0;
            overflow_q    <= 1'b0;
            squash_cnt_q  <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            overflow_q    <= overflow_d;
            squash_cnt_q  <= squash_cnt_d;
        end
    end

    // During a flush cycle the pre-flush head is still shown; decode
    // ignores it because it sees the hazard flags itself.
    assign id_valid_o      = ~fifo_empty;
    assign id_instr_o      = fifo_empty ? NopInstr : head_data[EntryW-1 -: DataWidth];
    assign id_pc_o         = fifo_empty ? '0 : head_data[AddrWidth:1];
    assign id_tag_o        = fifo_empty ? 1'b0 : head_data[0];
    assign id_count_o      = fifo_count;
    assign id_fetch_en_o   = fetch_en;
    assign id_overflow_o   = overflow_q;
    assign id_squash_cnt_o = squash_cnt_q;

endmodule
